// File: rtl/player_sprite_writer_if.sv
// Sprite ROM read port and framebuffer request/grant write port of the player sprite blitter.
interface player_sprite_writer_if #(
  parameter int unsigned PIX_W = 4,
  parameter int unsigned FB_AW = 15,
  parameter int unsigned RA_W  = 10
);
  logic [RA_W-1:0]  rom_addr;
  logic [PIX_W-1:0] rom_data;
  logic             fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [PIX_W-1:0] fb_data;
  logic             fb_gnt;

  modport master (
    output rom_addr, fb_we, fb_addr, fb_data,
    input  rom_data, fb_gnt
  );

  modport slave (
    input  rom_addr, fb_we, fb_addr, fb_data,
    output rom_data, fb_gnt
  );
endinterface

// File: rtl/player_sprite_writer.sv
// Blits the SPR_DIM x SPR_DIM player sprite into the palette framebuffer once per frame,
// skipping transparent and off-screen pixels; writes stall on the arbiter grant.
module player_sprite_writer #(
  parameter int unsigned FB_W        = 160,
  parameter int unsigned FB_H        = 144,
  parameter int unsigned SPR_DIM     = 16,
  parameter int unsigned PIX_W       = 4,
  parameter int unsigned TRANSPARENT = 0,
  parameter int unsigned FB_AW       = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [1:0] playerDir,
  input  logic [7:0] player_x,
  input  logic [7:0] player_y,
  player_sprite_writer_if.master bus,
  output logic       busy,
  output logic       done
);

  localparam int unsigned SPR_LOG  = $clog2(SPR_DIM);
  localparam int unsigned CNT_W    = 2 * SPR_LOG;
  localparam int unsigned RA_W     = 2 + CNT_W;
  localparam int unsigned LAST_PIX = SPR_DIM * SPR_DIM - 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_WRITE} state_e;

  state_e             state_q, state_d;
  logic               frame_clk_delayed_q, frame_clk_delayed_d;
  logic [1:0]         dir_q, dir_d;
  logic [7:0]         x_q, x_d;
  logic [7:0]         y_q, y_d;
  logic [CNT_W-1:0]   pix_q, pix_d;
  logic [RA_W-1:0]    rom_addr_q, rom_addr_d;
  logic               fb_we_q, fb_we_d;
  logic [FB_AW-1:0]   fb_addr_q, fb_addr_d;
  logic [PIX_W-1:0]   fb_data_q, fb_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SPR_LOG-1:0] col_c, row_c;
  logic [8:0]         sx_c, sy_c;
  logic               start_c, draw_c, adv_c, last_c;

  // Screen coordinates are formed at 9 bits so a sprite hanging off the edge never wraps on-screen.
  assign col_c   = pix_q[SPR_LOG-1:0];
  assign row_c   = pix_q[CNT_W-1:SPR_LOG];
  assign sx_c    = 9'(x_q) + 9'(col_c);
  assign sy_c    = 9'(y_q) + 9'(row_c);
  assign start_c = frame_clk & ~frame_clk_delayed_q;
  assign last_c  = (pix_q == CNT_W'(LAST_PIX));
  assign draw_c  = (bus.rom_data != PIX_W'(TRANSPARENT)) &&
                   (sx_c < 9'(FB_W)) && (sy_c < 9'(FB_H));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q             <= S_IDLE;
      frame_clk_delayed_q <= 1'b0;
      dir_q               <= '0;
      x_q                 <= '0;
      y_q                 <= '0;
      pix_q               <= '0;
      rom_addr_q          <= '0;
      fb_we_q             <= 1'b0;
      fb_addr_q           <= '0;
      fb_data_q           <= '0;
      busy_q              <= 1'b0;
      done_q              <= 1'b0;
    end else begin
      state_q             <= state_d;
      frame_clk_delayed_q <= frame_clk_delayed_d;
      dir_q               <= dir_d;
      x_q                 <= x_d;
      y_q                 <= y_d;
      pix_q               <= pix_d;
      rom_addr_q          <= rom_addr_d;
      fb_we_q             <= fb_we_d;
      fb_addr_q           <= fb_addr_d;
      fb_data_q           <= fb_data_d;
      busy_q              <= busy_d;
      done_q              <= done_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    frame_clk_delayed_d = frame_clk;
    dir_d               = dir_q;
    x_d                 = x_q;
    y_d                 = y_q;
    pix_d               = pix_q;
    rom_addr_d          = rom_addr_q;
    fb_we_d             = fb_we_q;
    fb_addr_d           = fb_addr_q;
    fb_data_d           = fb_data_q;
    done_d              = 1'b0;
    adv_c               = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          dir_d      = playerDir;
          x_d        = player_x;
          y_d        = player_y;
          pix_d      = '0;
          rom_addr_d = {playerDir, CNT_W'(0)};
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (draw_c) begin
          fb_addr_d = FB_AW'(sy_c) * FB_AW'(FB_W) + FB_AW'(sx_c);
          fb_data_d = bus.rom_data;
          fb_we_d   = 1'b1;
          state_d   = S_WRITE;
        end else begin
          adv_c = 1'b1;
        end
      end
      S_WRITE: begin
        if (bus.fb_gnt) begin
          fb_we_d = 1'b0;
          adv_c   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Raster-order advance: the ROM address for the next pixel is presented in its FETCH cycle.
    if (adv_c) begin
      if (last_c) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        pix_d      = pix_q + CNT_W'(1);
        rom_addr_d = {dir_q, pix_q + CNT_W'(1)};
        state_d    = S_FETCH;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = fb_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_player_sprite_writer.sv
// Directed bench for player_sprite_writer: a raster-level model predicts every write and the
// done cycle; literal expectations pin the model for each scenario.
module tb_player_sprite_writer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       gnt;
  logic [1:0] playerDir;
  logic [7:0] player_x, player_y;
  logic       busy, done;
  int         pat;
  int         passed = 0;
  int         total  = 0;

  typedef struct {int addr; int data;} wr_t;

  player_sprite_writer_if #(.PIX_W(4), .FB_AW(15), .RA_W(10)) bus ();

  player_sprite_writer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .playerDir (playerDir),
    .player_x  (player_x),
    .player_y  (player_y),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #10 Clk = ~Clk;

  // Pattern 0 opaque 5, 1 checkerboard (transparent on even col), 2 transparent, 3 index 8+dir.
  function automatic logic [3:0] rom_fn(input int p, input logic [9:0] a);
    case (p)
      0:       return 4'd5;
      1:       return a[0] ? 4'd7 : 4'd0;
      2:       return 4'd0;
      default: return 4'(8 + int'(a[9:8]));
    endcase
  endfunction

  always @(posedge Clk) bus.rom_data <= rom_fn(pat, bus.rom_addr);
  assign bus.fb_gnt = gnt;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run_blit(input logic [1:0] dir, input int x, input int y, input int p,
                          input int stalls, input bit mid_edge,
                          output int nw, output int first_a, output int last_a,
                          output int done_t, output int done_cnt);
    wr_t q[$];
    wr_t w;
    int  exp_done, stalls_left, prev_a, prev_d;
    bit  prev_st;
    pat      = p;
    exp_done = 1 + stalls;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int sx, sy;
        logic [3:0] px;
        sx = x + c;
        sy = y + r;
        px = rom_fn(p, {dir, 4'(r), 4'(c)});
        if (px != 4'd0 && sx < 160 && sy < 144) begin
          w.addr = sy * 160 + sx;
          w.data = int'(px);
          q.push_back(w);
          exp_done += 3;
        end else begin
          exp_done += 2;
        end
      end
    end
    nw = 0; first_a = -1; last_a = -1; done_t = -1; done_cnt = 0;
    stalls_left = stalls; prev_st = 1'b0; prev_a = 0; prev_d = 0;
    for (int t = 0; t <= exp_done + 8; t++) begin
      @(negedge Clk);
      check("busy", int'(busy), int'(t >= 1 && t < exp_done));
      check("done", int'(done), int'(t == exp_done));
      if (done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      if (busy) check("rom_dir", int'(bus.rom_addr[9:8]), int'(dir));
      else check("we_while_idle", int'(bus.fb_we), 0);
      if (prev_st) begin
        check("stall_we", int'(bus.fb_we), 1);
        check("stall_addr", int'(bus.fb_addr), prev_a);
        check("stall_data", int'(bus.fb_data), prev_d);
      end
      if (bus.fb_we && stalls_left > 0) begin
        gnt = 1'b0;
        stalls_left--;
      end else begin
        gnt = 1'b1;
      end
      prev_st = bus.fb_we && !gnt;
      prev_a  = int'(bus.fb_addr);
      prev_d  = int'(bus.fb_data);
      if (bus.fb_we && gnt) begin
        nw++;
        if (first_a < 0) first_a = int'(bus.fb_addr);
        last_a = int'(bus.fb_addr);
        if (q.size() == 0) begin
          check("unexpected_write_addr", int'(bus.fb_addr), -1);
        end else begin
          w = q.pop_front();
          check("write_addr", int'(bus.fb_addr), w.addr);
          check("write_data", int'(bus.fb_data), w.data);
        end
      end
      if (t == 0) begin
        playerDir = dir;
        player_x  = 8'(x);
        player_y  = 8'(y);
        frame_clk = 1'b1;
      end
      if (t == 3) frame_clk = 1'b0;
      if (mid_edge && t == 100) begin
        frame_clk = 1'b1;
        playerDir = ~dir;
        player_x  = 8'd77;
      end
      if (mid_edge && t == 104) frame_clk = 1'b0;
    end
    check("writes_left", q.size(), 0);
    check("done_pulses", done_cnt, 1);
    gnt = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},       int'(bus.fb_we), 0);
    check({tag, "_addr"},     int'(bus.fb_addr), 0);
    check({tag, "_data"},     int'(bus.fb_data), 0);
    check({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
    check({tag, "_busy"},     int'(busy), 0);
    check({tag, "_done"},     int'(done), 0);
  endtask

  initial begin
    int nw, fa, la, dt, dc, we_cnt, busy_cnt;
    Reset = 1'b1; frame_clk = 1'b0; gnt = 1'b1; pat = 0;
    playerDir = 2'd0; player_x = 8'd0; player_y = 8'd0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);

    // Fully opaque, on-screen.
    run_blit(2'b10, 10, 20, 0, 0, 1'b0, nw, fa, la, dt, dc);
    check("opaque_writes", nw, 256);
    check("opaque_first_addr", fa, 3210);
    check("opaque_last_addr", la, 5625);
    check("opaque_done_cycle", dt, 769);
    repeat (3) @(negedge Clk);

    // Clipped at the bottom-right corner.
    run_blit(2'b10, 150, 140, 0, 0, 1'b0, nw, fa, la, dt, dc);
    check("clip_writes", nw, 40);
    check("clip_first_addr", fa, 22550);
    check("clip_last_addr", la, 23039);
    check("clip_done_cycle", dt, 553);
    repeat (3) @(negedge Clk);

    // Checkerboard: odd columns only.
    run_blit(2'b00, 10, 20, 1, 0, 1'b0, nw, fa, la, dt, dc);
    check("checker_writes", nw, 128);
    check("checker_first_addr", fa, 3211);
    check("checker_done_cycle", dt, 641);
    repeat (3) @(negedge Clk);

    // Four-cycle grant stall on the first write.
    run_blit(2'b00, 0, 0, 0, 4, 1'b0, nw, fa, la, dt, dc);
    check("stall_writes", nw, 256);
    check("stall_first_addr", fa, 0);
    check("stall_done_cycle", dt, 773);
    repeat (3) @(negedge Clk);

    // Fully transparent.
    run_blit(2'b11, 10, 20, 2, 0, 1'b0, nw, fa, la, dt, dc);
    check("transparent_writes", nw, 0);
    check("transparent_done_cycle", dt, 513);
    repeat (3) @(negedge Clk);

    // Second frame edge and direction change mid-blit.
    run_blit(2'b01, 30, 40, 3, 0, 1'b1, nw, fa, la, dt, dc);
    check("midedge_writes", nw, 256);
    check("midedge_first_addr", fa, 6430);
    check("midedge_done_cycle", dt, 769);
    check("midedge_done_count", dc, 1);
    repeat (3) @(negedge Clk);

    // Reset while a write is held by a stalled grant.
    pat = 0; gnt = 1'b0;
    playerDir = 2'b10; player_x = 8'd10; player_y = 8'd20; frame_clk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      frame_clk = 1'b0;
      if (bus.fb_we) break;
    end
    check("rst_reached_write", int'(bus.fb_we), 1);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge Clk);
    Reset = 1'b0; gnt = 1'b1;
    we_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      we_cnt   += int'(bus.fb_we);
      busy_cnt += int'(busy);
    end
    check("post_rst_we_cycles", we_cnt, 0);
    check("post_rst_busy_cycles", busy_cnt, 0);

    run_blit(2'b10, 10, 20, 0, 0, 1'b0, nw, fa, la, dt, dc);
    check("recover_writes", nw, 256);
    check("recover_done_cycle", dt, 769);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
